// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the two-cache line memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GNT_IC = 2'b01;
  localparam logic [1:0] ST_GNT_DC = 2'b10;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IC   = 2'b01;
  localparam logic [1:0] OWN_DC   = 2'b10;

  typedef enum logic {
    LG_IC = 1'b0,
    LG_DC = 1'b1
  } last_grant_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way pick: bit 0 = I-cache, bit 1 = D-cache, one-hot grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic        [1:0] req,
  input  last_grant_e       last_grant,
  input  logic              fixed_prio,
  output logic        [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // A tie goes to the D-cache under fixed priority, otherwise to whoever did not win last.
      2'b11:   gnt = (fixed_prio || last_grant == LG_IC) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line memory port between I-cache and D-cache; grant registers mem_* one edge after the request,
// the owner holds the port until mem_ready, and every grant is separated by one IDLE cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_mem_read,
  input  logic              ic_mem_write,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  input  logic [LINE_W-1:0] ic_mem_wdata,
  output logic [LINE_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [LINE_W-1:0] dc_mem_wdata,
  output logic [LINE_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        arb_owner
);

  logic [1:0]  state;
  last_grant_e last_grant;
  logic [1:0]  req;
  logic [1:0]  gnt;

  assign req = {dc_mem_read | dc_mem_write, ic_mem_read | ic_mem_write};

  rr_arb2 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state      <= ST_IDLE;
      last_grant <= LG_IC;
      arb_owner  <= OWN_NONE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A write wins over a simultaneous read strobe from the same cache.
          if (gnt[1]) begin
            state      <= ST_GNT_DC;
            last_grant <= LG_DC;
            arb_owner  <= OWN_DC;
            mem_write  <= dc_mem_write;
            mem_read   <= dc_mem_read & ~dc_mem_write;
            mem_addr   <= dc_mem_addr;
            mem_wdata  <= dc_mem_wdata;
          end else if (gnt[0]) begin
            state      <= ST_GNT_IC;
            last_grant <= LG_IC;
            arb_owner  <= OWN_IC;
            mem_write  <= ic_mem_write;
            mem_read   <= ic_mem_read & ~ic_mem_write;
            mem_addr   <= ic_mem_addr;
            mem_wdata  <= ic_mem_wdata;
          end
        end
        ST_GNT_IC, ST_GNT_DC: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            arb_owner <= OWN_NONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          arb_owner <= OWN_NONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign ic_mem_ready = (state == ST_GNT_IC) & mem_ready;
  assign dc_mem_ready = (state == ST_GNT_DC) & mem_ready;
  assign ic_mem_rdata = mem_rdata;
  assign dc_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 round-robin, instance 1 fixed D-cache priority, both against a transaction model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;

  typedef struct { logic rd; logic wr; logic [AW-1:0] addr; logic [LW-1:0] wd; } txn_t;
  typedef struct { int who; logic wr; logic [AW-1:0] addr; } gnt_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ic_rd [2], ic_wr [2], dc_rd [2], dc_wr [2];
  logic [AW-1:0] ic_addr [2], dc_addr [2], m_addr [2];
  logic [LW-1:0] ic_wd [2], dc_wd [2], ic_rdat [2], dc_rdat [2], m_wd [2], m_rdat [2];
  logic ic_rdy [2], dc_rdy [2], m_rd [2], m_wr [2], m_rdy [2];
  logic [1:0] own [2];

  int total = 0;
  int bad = 0;

  // reference model: who owns the port and what was latched for it
  bit mbusy [2];
  int mown [2];
  int mlast [2];
  logic mrd [2], mwr [2];
  logic [AW-1:0] maddr [2];
  logic [LW-1:0] mwd [2];

  gnt_t dlog [2][$];
  txn_t rq [2][2][$];
  bit drv_en [2][2];
  bit seen [2][2];
  bit resp_en [2];
  int cnt [2];
  int lat [2];
  bit stray = 1'b0;
  logic [1:0] prev_own [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(g)) u_dut (
      .clk(clk), .proc_reset_n(rst_n),
      .ic_mem_read(ic_rd[g]), .ic_mem_write(ic_wr[g]), .ic_mem_addr(ic_addr[g]),
      .ic_mem_wdata(ic_wd[g]), .ic_mem_rdata(ic_rdat[g]), .ic_mem_ready(ic_rdy[g]),
      .dc_mem_read(dc_rd[g]), .dc_mem_write(dc_wr[g]), .dc_mem_addr(dc_addr[g]),
      .dc_mem_wdata(dc_wd[g]), .dc_mem_rdata(dc_rdat[g]), .dc_mem_ready(dc_rdy[g]),
      .mem_read(m_rd[g]), .mem_write(m_wr[g]), .mem_addr(m_addr[g]), .mem_wdata(m_wd[g]),
      .mem_rdata(m_rdat[g]), .mem_ready(m_rdy[g]), .arb_owner(own[g])
    );
  end

  task automatic chk(string tag, int i, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic drive(int i, int c, logic rd, logic wr, logic [AW-1:0] a, logic [LW-1:0] d);
    if (c == 0) begin
      ic_rd[i] = rd; ic_wr[i] = wr; ic_addr[i] = a; ic_wd[i] = d;
    end else begin
      dc_rd[i] = rd; dc_wr[i] = wr; dc_addr[i] = a; dc_wd[i] = d;
    end
  endtask

  task automatic push(int i, int c, logic rd, logic wr, logic [AW-1:0] a, logic [LW-1:0] d);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wd = d;
    rq[i][c].push_back(t);
  endtask

  task automatic run_q(int maxc);
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin seen[i][c] = 1'b0; drv_en[i][c] = 1'b1; end
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
      done = !mbusy[0] && !mbusy[1];
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) if (rq[i][c].size() != 0) done = 1'b0;
    end
    chk("queue_drain", 0, 128'(done), 128'(1));
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) drv_en[i][c] = 1'b0;
  endtask

  task automatic chk_log(int i, int idx, int who, logic wr, logic [AW-1:0] a);
    if (idx < dlog[i].size()) begin
      chk("order_who", i, 128'(dlog[i][idx].who), 128'(who));
      chk("order_wr", i, 128'(dlog[i][idx].wr), 128'(wr));
      chk("order_addr", i, 128'(dlog[i][idx].addr), 128'(a));
    end else begin
      chk("order_len", i, 128'(dlog[i].size()), 128'(idx + 1));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) dlog[i].delete();
  endtask

  task automatic wait_rdy(int i, int c, int maxc);
    int n = 0;
    while (((c == 0) ? ic_rdy[i] : dc_rdy[i]) !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  // model: steps once per edge, reset asynchronously
  initial begin
    int w;
    bit ric, rdc;
    for (int i = 0; i < 2; i++) begin
      mbusy[i] = 0; mown[i] = 0; mlast[i] = 1; mrd[i] = 0; mwr[i] = 0; maddr[i] = '0; mwd[i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          mbusy[i] = 0; mown[i] = 0; mlast[i] = 1; mrd[i] = 0; mwr[i] = 0; maddr[i] = '0; mwd[i] = '0;
        end else if (mbusy[i]) begin
          if (m_rdy[i]) begin mbusy[i] = 0; mown[i] = 0; mrd[i] = 0; mwr[i] = 0; end
        end else begin
          ric = ic_rd[i] | ic_wr[i];
          rdc = dc_rd[i] | dc_wr[i];
          w = 0;
          if (ric && rdc) w = (i == 1 || mlast[i] == 1) ? 2 : 1;
          else if (ric) w = 1;
          else if (rdc) w = 2;
          if (w == 1) begin
            mwr[i] = ic_wr[i]; mrd[i] = ic_rd[i] & ~ic_wr[i]; maddr[i] = ic_addr[i]; mwd[i] = ic_wd[i];
          end else if (w == 2) begin
            mwr[i] = dc_wr[i]; mrd[i] = dc_rd[i] & ~dc_wr[i]; maddr[i] = dc_addr[i]; mwd[i] = dc_wd[i];
          end
          if (w != 0) begin mbusy[i] = 1; mown[i] = w; mlast[i] = w; end
        end
      end
    end
  end

  // per-cycle comparison against the model, plus a log of grants as the DUT shows them
  initial begin
    prev_own[0] = 2'b00; prev_own[1] = 2'b00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("mem_read", i, 128'(m_rd[i]), 128'(mrd[i]));
        chk("mem_write", i, 128'(m_wr[i]), 128'(mwr[i]));
        chk("mem_addr", i, 128'(m_addr[i]), 128'(maddr[i]));
        chk("mem_wdata", i, m_wd[i], mwd[i]);
        chk("arb_owner", i, 128'(own[i]), 128'(mown[i]));
        chk("ic_ready", i, 128'(ic_rdy[i]), 128'(mown[i] == 1 && m_rdy[i] == 1'b1));
        chk("dc_ready", i, 128'(dc_rdy[i]), 128'(mown[i] == 2 && m_rdy[i] == 1'b1));
        chk("ic_rdata", i, ic_rdat[i], m_rdat[i]);
        chk("dc_rdata", i, dc_rdat[i], m_rdat[i]);
        if (own[i] != 2'b00 && prev_own[i] == 2'b00)
          dlog[i].push_back('{who: int'(own[i]), wr: m_wr[i], addr: m_addr[i]});
        prev_own[i] = own[i];
        if (drv_en[i][0] && ic_rdy[i] === 1'b1) seen[i][0] = 1'b1;
        if (drv_en[i][1] && dc_rdy[i] === 1'b1) seen[i][1] = 1'b1;
      end
    end
  end

  // memory: ready after lat cycles of strobe, optional stray ready while idle
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        m_rdat[i] = {$urandom, $urandom, $urandom, $urandom};
        if (!rst_n) begin
          cnt[i] = 0;
          if (resp_en[i]) m_rdy[i] = 1'b0;
        end else if (resp_en[i]) begin
          if (m_rdy[i]) begin
            m_rdy[i] = 1'b0; cnt[i] = 0; lat[i] = $urandom_range(1, 4);
          end else if (m_rd[i] || m_wr[i]) begin
            cnt[i]++;
            if (cnt[i] >= lat[i]) m_rdy[i] = 1'b1;
          end else if (stray && $urandom_range(0, 3) == 0) begin
            m_rdy[i] = 1'b1;
          end
        end
      end
    end
  end

  // requesters: hold the head transaction until its ready, then present the next
  initial begin
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++)
          if (drv_en[i][c]) begin
            if (seen[i][c] && rq[i][c].size() != 0) void'(rq[i][c].pop_front());
            seen[i][c] = 1'b0;
            if (rq[i][c].size() != 0)
              drive(i, c, rq[i][c][0].rd, rq[i][c][0].wr, rq[i][c][0].addr, rq[i][c][0].wd);
            else
              drive(i, c, 1'b0, 1'b0, '0, '0);
          end
    end
  end

  initial begin
    int base [2];
    int pushed [2];
    int k;
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b0, 1'b0, '0, '0);
      drive(i, 1, 1'b0, 1'b0, '0, '0);
      m_rdy[i] = 1'b0; m_rdat[i] = '0; resp_en[i] = 1'b1; cnt[i] = 0; lat[i] = 3;
    end
    #1 rst_n = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("rst_read", i, 128'(m_rd[i]), 128'(0));
      chk("rst_write", i, 128'(m_wr[i]), 128'(0));
      chk("rst_addr", i, 128'(m_addr[i]), 128'(0));
      chk("rst_wdata", i, m_wd[i], 128'(0));
      chk("rst_owner", i, 128'(own[i]), 128'(0));
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // I-cache alone, memory answers after 3 strobe cycles
    lat[0] = 3;
    @(posedge clk); #2 drive(0, 0, 1'b1, 1'b0, 28'h0000123, '0);
    @(negedge clk);
    chk("t1_not_yet", 0, 128'(m_rd[0]), 128'(0));
    @(negedge clk);
    chk("t1_read", 0, 128'(m_rd[0]), 128'(1));
    chk("t1_addr", 0, 128'(m_addr[0]), 128'(28'h0000123));
    chk("t1_owner", 0, 128'(own[0]), 128'(2'b01));
    wait_rdy(0, 0, 20);
    chk("t1_ic_ready", 0, 128'(ic_rdy[0]), 128'(1));
    chk("t1_dc_ready", 0, 128'(dc_rdy[0]), 128'(0));
    @(posedge clk); #2 drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_gap", 0, 128'(m_rd[0]), 128'(0));
    chk("t1_idle_owner", 0, 128'(own[0]), 128'(0));

    // simultaneous I read / D write right after reset
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, 0, 1'b1, 1'b0, 28'h10, '0);
      push(i, 1, 1'b0, 1'b1, 28'h20, a5);
    end
    run_q(60);
    for (int i = 0; i < 2; i++) begin
      chk_log(i, 0, 2, 1'b1, 28'h20);
      chk_log(i, 1, 1, 1'b0, 28'h10);
    end

    // D-cache requests continuously for three lines while I-cache waits
    do_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) push(i, 1, 1'b1, 1'b0, 28'(32'h30 + j), '0);
      push(i, 0, 1'b1, 1'b0, 28'h40, '0);
    end
    run_q(100);
    chk_log(0, 0, 2, 1'b0, 28'h30);
    chk_log(0, 1, 1, 1'b0, 28'h40);
    chk_log(0, 2, 2, 1'b0, 28'h31);
    chk_log(0, 3, 2, 1'b0, 28'h32);
    chk_log(1, 0, 2, 1'b0, 28'h30);
    chk_log(1, 1, 2, 1'b0, 28'h31);
    chk_log(1, 2, 2, 1'b0, 28'h32);
    chk_log(1, 3, 1, 1'b0, 28'h40);

    // write-back then refill from D-cache with an I-cache read pending
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, 1, 1'b0, 1'b1, 28'h50, a5);
      push(i, 1, 1'b1, 1'b0, 28'h50, '0);
      push(i, 0, 1'b1, 1'b0, 28'h60, '0);
    end
    run_q(100);
    chk_log(0, 0, 2, 1'b1, 28'h50);
    chk_log(0, 1, 1, 1'b0, 28'h60);
    chk_log(0, 2, 2, 1'b0, 28'h50);
    chk_log(1, 0, 2, 1'b1, 28'h50);
    chk_log(1, 1, 2, 1'b0, 28'h50);
    chk_log(1, 2, 1, 1'b0, 28'h60);

    // owner drops its strobe right after the grant
    lat[0] = 3;
    @(posedge clk); #2 drive(0, 0, 1'b1, 1'b0, 28'h55, '0);
    @(posedge clk); #2 drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t5_hold", 0, 128'(m_rd[0]), 128'(1));
    wait_rdy(0, 0, 20);
    chk("t5_ready", 0, 128'(ic_rdy[0]), 128'(1));
    chk("t5_hold_end", 0, 128'(m_rd[0]), 128'(1));
    @(negedge clk);
    chk("t5_released", 0, 128'(m_rd[0]), 128'(0));
    chk("t5_owner", 0, 128'(own[0]), 128'(0));

    // reset lands mid-transaction on both instances
    for (int i = 0; i < 2; i++) begin resp_en[i] = 1'b0; m_rdy[i] = 1'b0; end
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) drive(i, 1, 1'b0, 1'b1, 28'h77, a5);
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) drive(i, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("t6_active", i, 128'(m_wr[i]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t6_async_write", i, 128'(m_wr[i]), 128'(0));
      chk("t6_async_owner", i, 128'(own[i]), 128'(0));
    end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) m_rdy[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t6_late_ready", i, 128'(dc_rdy[i]), 128'(0));
      chk("t6_late_owner", i, 128'(own[i]), 128'(0));
    end
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) begin m_rdy[i] = 1'b0; resp_en[i] = 1'b1; dlog[i].delete(); end
    for (int i = 0; i < 2; i++) push(i, 0, 1'b1, 1'b0, 28'h88, '0);
    run_q(40);
    for (int i = 0; i < 2; i++) chk_log(i, 0, 1, 1'b0, 28'h88);

    // random traffic, including both strobes high and stray idle readies
    stray = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 2; i++) begin
        base[i] = dlog[i].size();
        pushed[i] = 0;
        for (int c = 0; c < 2; c++) begin
          k = $urandom_range(0, 3);
          for (int j = 0; j < k; j++) begin
            case ($urandom_range(0, 2))
              0: push(i, c, 1'b1, 1'b0, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
              1: push(i, c, 1'b0, 1'b1, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
              default: push(i, c, 1'b1, 1'b1, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
            endcase
            pushed[i]++;
          end
        end
      end
      run_q(400);
      for (int i = 0; i < 2; i++)
        chk("rand_grants", i, 128'(dlog[i].size() - base[i]), 128'(pushed[i]));
    end
    stray = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit line memory port between the instruction cache and the data cache.
- Each cache drives its own copy of the cache-side memory handshake: read/write strobes held until ready, 28-bit line address, 128-bit line data.
- Grants one requester at a time, forwards that transaction to memory through registered outputs, and returns mem_ready only to the owner.
- Arbitration is round-robin by default, with a fixed data-cache-priority option.

Parameters:
- ADDR_W, 28, line address width
- LINE_W, 128, line data width
- FIXED_PRIO, 0, 0 = round-robin; 1 = data cache always wins a simultaneous request

Ports:
- clk  in  1  system clock, rising edge
- proc_reset_n  in  1  asynchronous, active-low reset
- ic_mem_read  in  1  I-cache line read request
- ic_mem_write  in  1  I-cache line write request
- ic_mem_addr  in  ADDR_W  I-cache line address
- ic_mem_wdata  in  LINE_W  I-cache write line
- ic_mem_rdata  out  LINE_W  read line to I-cache
- ic_mem_ready  out  1  transaction complete, I-cache
- dc_mem_read  in  1  D-cache line read request
- dc_mem_write  in  1  D-cache line write request
- dc_mem_addr  in  ADDR_W  D-cache line address
- dc_mem_wdata  in  LINE_W  D-cache write line
- dc_mem_rdata  out  LINE_W  read line to D-cache
- dc_mem_ready  out  1  transaction complete, D-cache
- mem_read  out  1  memory read strobe (registered)
- mem_write  out  1  memory write strobe (registered)
- mem_addr  out  ADDR_W  memory line address (registered)
- mem_wdata  out  LINE_W  memory write line (registered)
- mem_rdata  in  LINE_W  memory read line
- mem_ready  in  1  memory transaction complete
- arb_owner  out  2  00 none, 01 I-cache, 10 D-cache

Behaviour:
- Reset (asynchronous, proc_reset_n low):
  - state = IDLE, last_grant = IC, arb_owner = 00.
  - mem_read, mem_write, mem_addr, mem_wdata all 0.
  - Any in-flight memory transaction is abandoned; no ready is forwarded.
- Request definition: a requester requests when its read or write strobe is high. If both strobes are high, the write is forwarded and the read is ignored (illegal input).
- State IDLE:
  - Requests are sampled at the clock edge.
  - One requester: grant it.
  - Both requesting, FIXED_PRIO = 0: grant the requester that is not last_grant.
  - Both requesting, FIXED_PRIO = 1: grant the D-cache.
  - On grant: register the owner's strobe, address and wdata into the mem_* outputs; go to GNT_IC or GNT_DC; update last_grant and arb_owner.
  - Latency: request visible at edge t gives mem_* asserted after edge t.
- States GNT_IC / GNT_DC:
  - mem_* outputs hold the latched values. Requester inputs are ignored, including a requester dropping its strobe mid-transaction; the memory transaction still completes.
  - The owner's *_mem_ready = mem_ready (combinational). The other requester's ready is 0.
  - When mem_ready is sampled high: clear mem_read/mem_write, arb_owner = 00, go to IDLE.
- Strobe gap: mem_read/mem_write are low for at least one cycle between consecutive transactions (guaranteed by the IDLE cycle).
- Back-to-back from one cache: a requester may re-raise a new request in the cycle after its ready (e.g. write-back followed by refill). It is arbitrated normally. Under round-robin the other pending requester wins first.
- Read data: ic_mem_rdata and dc_mem_rdata are both driven with mem_rdata unconditionally. Only the gated ready qualifies the data.
- Ready outside a grant: mem_ready high in IDLE is ignored and forwards nothing.
- Starvation: under round-robin, a continuously requesting cache waits at most one transaction.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE = 2'b00, GNT_IC = 2'b01, GNT_DC = 2'b10
  - owner encodings (match arb_owner)
  - ADDR_W and LINE_W defaults
- Sub-module rr_arb2: combinational 2-way pick.
  - Inputs: req[1:0], last_grant, fixed_prio.
  - Output: one-hot gnt[1:0].
- Top level holds the FSM, the output registers and the ready gating.

Test Plan:
- I-cache only: ic_mem_read = 1, ic_mem_addr = 28'h0000123; memory ready after 3 cycles -> mem_read = 1 with mem_addr = 28'h0000123 from the cycle after the request; ic_mem_ready pulses with mem_ready; dc_mem_ready stays 0; mem_read low the next cycle.
- Simultaneous requests, FIXED_PRIO = 0, last_grant = IC after reset:
  - Stimulus: ic read 28'h10, dc write 28'h20, wdata 128'hA5...A5.
  - Required: DC granted first (mem_write = 1, mem_wdata = A5...A5); after its ready, one idle cycle, then IC granted (mem_read = 1, addr 28'h10).
- FIXED_PRIO = 1, both requesting continuously for 3 transactions -> DC granted every time; IC never granted while DC requests.
- Write-back followed by refill from the D-cache while the I-cache has a pending request -> order DC write, IC read, DC read; a single-cycle strobe gap between each transaction.
- Requester drops its strobe mid-transaction -> mem_read stays 1 until mem_ready; owner's ready still pulses; arbiter returns to IDLE.
- proc_reset_n pulsed low mid-transaction -> mem_read/mem_write = 0 and arb_owner = 00 immediately, without waiting for a clock edge; a later mem_ready is ignored; a fresh request after reset is granted normally.
